// File: rtl/countdown_ms_timer.sv
// countdown_ms_timer
//
// Millisecond elapsed-time generator for the countdown display path. A start
// request launches a prescaled millisecond counter at 1. The counter then runs
// up to END_MS, emits a one-cycle GO pulse, and holds until it is restarted or
// aborted.
//
// Parameters:
//   TICK_DIV  CLK cycles per millisecond tick (2..65535)
//   END_MS    terminal COUNT1 value in ms (2..2^32-1)
//
// Ports:
//   CLK      in   single clock, rising edge
//   RESETN   in   asynchronous active-low reset
//   START    in   synchronous start/restart request (ignored while running)
//   ABORT    in   synchronous abort, beats START and the terminal tick
//   PAUSE    in   freeze counting in RUN (only with COUNTDOWN_PAUSE_EN)
//   COUNT1   out  elapsed milliseconds, registered
//   RUNNING  out  high while counting
//   GO       out  one-cycle pulse when COUNT1 reaches END_MS
//   DONE     out  high from the GO cycle until restart/abort
//
// Build option: define COUNTDOWN_PAUSE_EN to add the PAUSE port.
// All outputs are driven from registers, so there is no input-to-output
// combinational path.

module countdown_ms_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned END_MS   = 3000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic        ABORT,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic        PAUSE,
`endif
  output logic [31:0] COUNT1,
  output logic        RUNNING,
  output logic        GO,
  output logic        DONE
);

  localparam int unsigned    PreW    = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [31:0]    EndMs   = END_MS;

  typedef enum logic [1:0] {StIdle, StRun, StGo, StHold} state_e;

  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic [31:0]     count_q;
  logic            running_q;
  logic            go_q;
  logic            done_q;

  logic        freeze;
  logic [31:0] count_inc;

`ifdef COUNTDOWN_PAUSE_EN
  assign freeze = PAUSE;
`else
  assign freeze = 1'b0;
`endif

  assign count_inc = count_q + 32'd1;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
    end else if (ABORT) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q   <= StRun;
            pre_q     <= '0;
            count_q   <= 32'd1;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (!freeze) begin
            if (pre_q == PreLast) begin
              pre_q   <= '0;
              count_q <= count_inc;
              // Terminal tick: the GO pulse shows together with COUNT1 == END_MS.
              if (count_inc == EndMs) begin
                state_q   <= StGo;
                running_q <= 1'b0;
                go_q      <= 1'b1;
                done_q    <= 1'b1;
              end
            end else begin
              pre_q <= pre_q + PreW'(1);
            end
          end
        end
        StGo: begin
          state_q <= StHold;
          go_q    <= 1'b0;
        end
        StHold: begin
          if (START) begin
            state_q   <= StRun;
            pre_q     <= '0;
            count_q   <= 32'd1;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          pre_q     <= '0;
          count_q   <= '0;
          running_q <= 1'b0;
          go_q      <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign COUNT1  = count_q;
  assign RUNNING = running_q;
  assign GO      = go_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_countdown_ms_timer.sv
// Bench for countdown_ms_timer with TICK_DIV=4, END_MS=10. The reference model
// tracks the elapsed cycles since the last start and derives the expected
// millisecond count arithmetically.

module tb_countdown_ms_timer;

  localparam int unsigned TD = 4;
  localparam int unsigned EM = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        pause;
  logic [31:0] count1;
  logic        running;
  logic        go;
  logic        done;

  always #5 clk = ~clk;

  countdown_ms_timer #(
    .TICK_DIV (TD),
    .END_MS   (EM)
  ) dut (
    .CLK     (clk),
    .RESETN  (resetn),
    .START   (start),
    .ABORT   (abort),
`ifdef COUNTDOWN_PAUSE_EN
    .PAUSE   (pause),
`endif
    .COUNT1  (count1),
    .RUNNING (running),
    .GO      (go),
    .DONE    (done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model.
  typedef enum int {MIdle, MRun, MGo, MHold} m_mode_t;
  m_mode_t m_mode    = MIdle;
  int      m_elapsed = 0;
  int      m_runs    = 0;

  // Independent monitors: bound on COUNT1, GO pulse count and GO width.
  int go_seen  = 0;
  int viol_cnt = 0;
  logic go_prev = 1'b0;

  always @(negedge clk) begin
    if (count1 > EM) viol_cnt++;
    if (go && go_prev) viol_cnt++;
    if (go) go_seen++;
    go_prev = go;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic a, input logic p);
    if (a) begin
      m_mode    = MIdle;
      m_elapsed = 0;
    end else begin
      case (m_mode)
        MIdle: if (s) begin m_mode = MRun; m_elapsed = 0; end
        MRun: begin
          if (!p) m_elapsed++;
          if (1 + m_elapsed / TD >= EM) begin
            m_mode = MGo;
            m_runs++;
          end
        end
        MGo:   m_mode = MHold;
        MHold: if (s) begin m_mode = MRun; m_elapsed = 0; end
        default: m_mode = MIdle;
      endcase
    end
  endtask

  task automatic check_model();
    int unsigned ec;
    case (m_mode)
      MIdle:   ec = 0;
      MRun:    ec = 1 + m_elapsed / TD;
      default: ec = EM;
    endcase
    check("m_count1", count1, ec);
    check("m_running", 32'(running), 32'(m_mode == MRun));
    check("m_go", 32'(go), 32'(m_mode == MGo));
    check("m_done", 32'(done), 32'(m_mode == MGo || m_mode == MHold));
  endtask

  // Drive inputs for one edge, then check just after it.
  task automatic cycle(input logic s, input logic a, input logic p);
    start = s;
    abort = a;
    pause = p;
    @(posedge clk);
    model_edge(s, a, p);
    #1;
    check_model();
  endtask

  initial begin
    logic rs, ra, rp;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    pause  = 1'b0;
    #12;
    check("rst_count1", count1, 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_go", 32'(go), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #5 resetn = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Full run: START at edge N.
    cycle(1'b1, 1'b0, 1'b0);
    check("run_n_count1", count1, 32'd1);
    check("run_n_running", 32'(running), 32'd1);
    for (int k = 1; k <= 37; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (k == 4) check("run_n4_count1", count1, 32'd2);
      if (k == 35) check("run_n35_go", 32'(go), 32'd0);
      if (k == 36) begin
        check("run_n36_count1", count1, 32'd10);
        check("run_n36_go", 32'(go), 32'd1);
        check("run_n36_done", 32'(done), 32'd1);
      end
      if (k == 37) begin
        check("run_n37_go", 32'(go), 32'd0);
        check("run_n37_done", 32'(done), 32'd1);
        check("run_n37_count1", count1, 32'd10);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Restart from HOLD, with START held through most of the run.
    cycle(1'b1, 1'b0, 1'b0);
    check("restart_count1", count1, 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_running", 32'(running), 32'd1);
    for (int k = 1; k <= 35; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (k == 32) check("held_start_count1", count1, 32'd9);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check("held_start_go", 32'(go), 32'd1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);

    // Abort beats START on the terminal tick.
    cycle(1'b0, 1'b1, 1'b0);
    check("abort_hold_count1", count1, 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 35; k++) cycle(1'b0, 1'b0, 1'b0);
    check("abort_pre_count1", count1, 32'd9);
    cycle(1'b1, 1'b1, 1'b0);
    check("abort_count1", count1, 32'd0);
    check("abort_go", 32'(go), 32'd0);
    check("abort_running", 32'(running), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at COUNT1 == 5.
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) cycle(1'b0, 1'b0, 1'b0);
    check("pre_reset_count1", count1, 32'd5);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_count1", count1, 32'd0);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_go", 32'(go), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    m_mode    = MIdle;
    m_elapsed = 0;
    #2 resetn = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

`ifdef COUNTDOWN_PAUSE_EN
    // Pause for 7 cycles at COUNT1 == 3; GO moves out to N+43.
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b0, 1'b0);
    check("pause_pre_count1", count1, 32'd3);
    for (int k = 9; k <= 15; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("pause_count1", count1, 32'd3);
      check("pause_running", 32'(running), 32'd1);
    end
    for (int k = 16; k <= 44; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (k == 36) check("pause_n36_go", 32'(go), 32'd0);
      if (k == 43) check("pause_n43_go", 32'(go), 32'd1);
      if (k == 44) check("pause_n44_go", 32'(go), 32'd0);
    end
    cycle(1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 7) == 0);
      ra = ($urandom_range(0, 59) == 0);
`ifdef COUNTDOWN_PAUSE_EN
      rp = ($urandom_range(0, 3) == 0);
`else
      rp = 1'b0;
`endif
      cycle(rs, ra, rp);
    end
    cycle(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check("go_pulse_count", go_seen, m_runs);
    check("bound_and_width", viol_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_ms_timer.md
# countdown_ms_timer

Millisecond elapsed-time generator that drives the 32-bit `COUNT1` bus consumed by the game's countdown display decoder. On a start request it runs a prescaled millisecond counter from 1 up to a terminal value. At the terminal value it emits a one-cycle `GO` pulse, then holds until restarted or aborted. It sits between the game-control FSM (which issues `START`/`ABORT`) and the countdown decoder/display path.

## Interface
- `TICK_DIV`, default 1000: `CLK` cycles per millisecond tick; legal range 2..65535.
- `END_MS`, default 3000: terminal `COUNT1` value in ms; legal range 2..2^32-1.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RESETN` input, 1 bit: asynchronous, active-low reset.
- `START` input, 1 bit: synchronous start request, sampled each rising edge.
- `ABORT` input, 1 bit: synchronous abort; has priority over `START`.
- `PAUSE` input, 1 bit: freeze request; present only when `COUNTDOWN_PAUSE_EN` is defined.
- `COUNT1` output, 32 bits: elapsed milliseconds, registered.
- `RUNNING` output, 1 bit: high while in RUN.
- `GO` output, 1 bit: one-cycle pulse on reaching `END_MS`.
- `DONE` output, 1 bit: high in GO and HOLD.

## Operation
- States: IDLE, RUN, GO, HOLD. Internal prescaler `PRE` with width ceil(log2(`TICK_DIV`)).
- IDLE:
  - `START`=1 -> RUN, with `COUNT1`<=1 and `PRE`<=0.
  - Otherwise stay in IDLE, with `COUNT1`=0.
- RUN:
  - `PRE` increments every cycle.
  - When `PRE`==`TICK_DIV`-1: `PRE`<=0 and `COUNT1`<=`COUNT1`+1.
  - If that increment produces `END_MS`, the next state is GO.
  - `START` is ignored in RUN.
- GO: lasts exactly one cycle. `COUNT1`=`END_MS`, `GO`=1. Unconditionally -> HOLD unless `ABORT`.
- HOLD:
  - `COUNT1` stays at `END_MS`.
  - `START`=1 -> RUN (restart, `COUNT1`<=1, `PRE`<=0).
  - Otherwise stay in HOLD.
- `ABORT`=1 in any state: next state IDLE, `COUNT1`<=0, `PRE`<=0. Wins over a simultaneous `START` or terminal tick.
- Arithmetic:
  - `COUNT1` never exceeds `END_MS` and never wraps.
  - `PRE` compare is equality against `TICK_DIV`-1.
- Outputs are decoded from registered state or registered directly. There is no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous assert, `RESETN`=0): state IDLE, `COUNT1`=0, `PRE`=0, `RUNNING`=0, `GO`=0, `DONE`=0. Release is synchronous to the next `CLK` edge.
- `START` sampled at edge N: `COUNT1`=1 and `RUNNING`=1 are visible after edge N.
- `COUNT1` step k (value k+1) occurs k·`TICK_DIV` cycles after edge N.
- `GO` asserts (`END_MS`-1)·`TICK_DIV` cycles after edge N, for exactly one cycle. `DONE` rises on the same cycle and remains high through HOLD.
- Reset asserted mid-RUN: outputs go to their reset values immediately, with no clock needed.

## Configuration
- `COUNTDOWN_PAUSE_EN` defined:
  - The `PAUSE` port exists.
  - In RUN with `PAUSE`=1, `PRE` and `COUNT1` hold and `RUNNING` stays 1.
  - `ABORT` still takes effect during `PAUSE`. `PAUSE` has no effect in other states.
- `COUNTDOWN_PAUSE_EN` undefined: no `PAUSE` port; RUN counts unconditionally.

## Test plan
All scenarios use `TICK_DIV`=4 and `END_MS`=10.
- Reset: `RESETN` low mid-RUN (`COUNT1`=5) -> `COUNT1`=0, `RUNNING`=0, `GO`=0, `DONE`=0 with no clock edge. After release, stays IDLE.
- Full run:
  - Stimulus: `START` pulse at edge N.
  - Required: `COUNT1`=1 after N; `COUNT1`=2 after N+4; `COUNT1`=10 and `GO`=1 after N+36.
  - Required: `GO`=0 after N+37 while `DONE`=1 and `COUNT1`=10 hold.
- Ignore/restart: `START` held continuously during RUN -> count unaffected. `START` in HOLD -> `COUNT1`=1, `DONE`=0, `RUNNING`=1 next cycle.
- Abort priority: `ABORT` and `START` together on the cycle of the terminal tick (`COUNT1`=9) -> IDLE, `COUNT1`=0, no `GO` pulse.
- Pause (`COUNTDOWN_PAUSE_EN`): `PAUSE`=1 for 7 cycles at `COUNT1`=3 -> `COUNT1` stays 3. `GO` arrives 7 cycles later than the unpaused run (N+43).
- Monotonic check (assertion, all runs): `COUNT1` never exceeds 10. `GO` is high for exactly one cycle per completed run.
